clk_period_meter: RTL

//  Measures a slow clock produced by the programmable clock divider and reports its

---
 rtl/clk_period_meter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
// Purpose: measures period and high time of an asynchronous slow clock in i_wb_clk cycles.
// Latency: result registered one cycle after the synchronized closing rise (sync + edge reg ahead).
// Backpressure: none; o_valid is a single-cycle pulse and results hold until the next update.
module clk_period_meter #(
  parameter int CNT_W       = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  input  logic             i_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] h_lat;
  logic [CNT_W-1:0] h_lat_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] high_nxt;
  logic             valid_nxt;
  logic             ovf_nxt;

  // Synchronizer chain for the asynchronous input, followed by the edge register.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_sig};
      s_d  <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // State, counter, latched high time and the registered results.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      h_lat    <= '0;
      o_period <= '0;
      o_high   <= '0;
      o_valid  <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      h_lat    <= h_lat_nxt;
      o_period <= period_nxt;
      o_high   <= high_nxt;
      o_valid  <= valid_nxt;
      o_ovf    <= ovf_nxt;
    end
  end

  // Next-state and result logic; saturation takes priority over any edge so a
  // stuck or too-slow input always falls back to ARM instead of hanging.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    h_lat_nxt  = h_lat;
    period_nxt = o_period;
    high_nxt   = o_high;
    valid_nxt  = 1'b0;
    ovf_nxt    = o_ovf;

    if (!i_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          cnt_nxt   = '0;
        end
        ARM: begin
          cnt_nxt = '0;
          if (rise) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = MEAS_HIGH;
          end
        end
        MEAS_HIGH, MEAS_LOW: begin
          if (cnt == CNT_MAX) begin
            ovf_nxt   = 1'b1;
            state_nxt = ARM;
          end else if (rise) begin
            // A rise while still in MEAS_HIGH means the fall was missed: restart quietly.
            cnt_nxt   = CNT_ONE;
            state_nxt = MEAS_HIGH;
            if (state == MEAS_LOW) begin
              period_nxt = cnt;
              high_nxt   = h_lat;
              valid_nxt  = 1'b1;
              ovf_nxt    = 1'b0;
            end
          end else if (fall && state == MEAS_HIGH) begin
            h_lat_nxt = cnt;
            state_nxt = MEAS_LOW;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule
